// File: rtl/cm0ik_rst_pkg.sv
// Shared constants for the reset controller: state encoding, RSTCAUSE bit map, hold default.
package cm0ik_rst_pkg;

  localparam logic [1:0] ST_POR_HOLD = 2'd0;
  localparam logic [1:0] ST_SYS_HOLD = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;

  localparam int RC_POR  = 0;
  localparam int RC_SYS  = 1;
  localparam int RC_LOCK = 2;
  localparam int RC_EXT  = 3;

  localparam int HOLD_DEFAULT = 3;

  function automatic logic [3:0] cause_bits(input logic sys, input logic lock, input logic ext);
    logic [3:0] bits;
    bits          = 4'b0000;
    bits[RC_SYS]  = sys;
    bits[RC_LOCK] = lock;
    bits[RC_EXT]  = ext;
    return bits;
  endfunction

endpackage

// File: rtl/cm0ik_rst_sync.sv
// Two-flop synchroniser for one asynchronous level; both flops load RST_VAL under reset.
module cm0ik_rst_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cm0ik_rstctrl.sv
// System/debug reset sequencer with hold timer and sticky reset-cause register.
//   state       | meaning
//   POR_HOLD    | power-on hold: HRESETn=0, DBGRESETn=0
//   SYS_HOLD    | system reset hold: HRESETn=0, DBGRESETn=1
//   RUN         | both resets released
module cm0ik_rstctrl
  import cm0ik_rst_pkg::*;
#(
  parameter int HOLD  = HOLD_DEFAULT,
  parameter int CNT_W = 4
) (
  input  logic       HCLK,
  input  logic       PORESET,
  input  logic       SYSRESETREQ,
  input  logic       LOCKUP,
  input  logic       LOCKUPRESET,
  input  logic       EXTRESETn,
  input  logic       RSTCAUSECLR,
  output logic       HRESETn,
  output logic       DBGRESETn,
  output logic [3:0] RSTCAUSE
);

  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       cause, cause_nxt;
  logic             ext_sync;
  logic             ext_req;
  logic             lock_req;
  logic             req;
  logic             hrst_q, dbg_q;

  cm0ik_rst_sync #(.RST_VAL(1'b1)) u_ext_sync (
    .clk (HCLK),
    .rst (PORESET),
    .d   (EXTRESETn),
    .q   (ext_sync)
  );

  assign ext_req  = ~ext_sync;
  assign lock_req = LOCKUP & LOCKUPRESET;
  assign req      = SYSRESETREQ | lock_req | ext_req;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cause_nxt = cause;
    case (state)
      ST_POR_HOLD, ST_SYS_HOLD: begin
        // a live request in SYS_HOLD keeps restarting the hold window
        if ((state == ST_SYS_HOLD) && req) begin
          cnt_nxt = '0;
        end else if (cnt == HOLD_M1) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (req) begin
          state_nxt = ST_SYS_HOLD;
          cnt_nxt   = '0;
          cause_nxt = (RSTCAUSECLR ? 4'b0000 : cause) |
                      cause_bits(SYSRESETREQ, lock_req, ext_req);
        end else if (RSTCAUSECLR) begin
          cause_nxt = 4'b0000;
        end
      end
      default: begin
        state_nxt = ST_POR_HOLD;
        cnt_nxt   = '0;
      end
    endcase
  end

  // outputs are flops loaded from the next state so they never glitch
  always_ff @(posedge HCLK) begin
    if (PORESET) begin
      state  <= ST_POR_HOLD;
      cnt    <= '0;
      cause  <= 4'b0001;
      hrst_q <= 1'b0;
      dbg_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      cause  <= cause_nxt;
      hrst_q <= (state_nxt == ST_RUN);
      dbg_q  <= (state_nxt != ST_POR_HOLD);
    end
  end

  assign HRESETn   = hrst_q;
  assign DBGRESETn = dbg_q;
  assign RSTCAUSE  = cause;

endmodule

// File: doc/cm0ik_rstctrl.md
CM0IK_RSTCTRL -- requirements
Module: cm0ik_rstctrl

Interface
REQ-001 SHALL have parameter: HOLD, 3, reset-hold length in HCLK cycles (legal range 1..15).
REQ-002 SHALL have parameter: CNT_W, 4, hold-counter width.
REQ-003 SHALL have port: HCLK  input  1  system clock; the only clock.
REQ-004 SHALL have port: PORESET  input  1  power-on reset; synchronous, active-high; driven from the power-on reset generator, inverted.
REQ-005 SHALL have port: SYSRESETREQ  input  1  system reset request from the core.
REQ-006 SHALL have port: LOCKUP  input  1  core lockup indication.
REQ-007 SHALL have port: LOCKUPRESET  input  1  enable reset on lockup.
REQ-008 SHALL have port: EXTRESETn  input  1  external reset button; asynchronous, active-low.
REQ-009 SHALL have port: RSTCAUSECLR  input  1  clear pulse for RSTCAUSE.
REQ-010 SHALL have port: HRESETn  output  1  system/AHB reset, active-low.
REQ-011 SHALL have port: DBGRESETn  output  1  debug reset, active-low; asserted by PORESET only.
REQ-012 SHALL have port: RSTCAUSE  output  4  sticky cause: [0] POR, [1] SYSRESETREQ, [2] LOCKUP, [3] EXT.

Function
REQ-013 SHALL implement an FSM with three states: POR_HOLD, SYS_HOLD and RUN.
REQ-014 SHALL decode outputs from registered state only: HRESETn = (state==RUN), DBGRESETn = (state!=POR_HOLD), both glitch-free.
REQ-015 SHALL, while PORESET=1 at a rising edge, go to POR_HOLD with cnt=0 and RSTCAUSE=4'b0001, overriding all other inputs.
REQ-016 SHALL, in POR_HOLD with PORESET=0, increment cnt each cycle and enter RUN on the edge where cnt==HOLD-1, so HRESETn rises on the HOLD-th edge after PORESET falls.
REQ-017 SHALL define req = SYSRESETREQ | (LOCKUP & LOCKUPRESET) | ext_req, where ext_req is the synchronised, inverted EXTRESETn.
REQ-018 SHALL synchronise EXTRESETn through two flops; ext_req reaches the FSM on the 2nd edge after sampling, and HRESETn falls on the 3rd edge.
REQ-019 SHALL, in RUN with req=1, enter SYS_HOLD with cnt=0 on the next edge.
REQ-020 SHALL, in that RUN-to-SYS_HOLD transition, OR each contributing source into RSTCAUSE[3:1].
REQ-021 SHALL hold cnt at 0 in SYS_HOLD while req=1, so a new or continuing request restarts the hold.
REQ-022 SHALL, in SYS_HOLD once req=0, count as in REQ-016 and return to RUN.
REQ-023 SHALL never assert DBGRESETn low on a SYS_HOLD entry.
REQ-024 SHALL clear RSTCAUSE to 0 on RSTCAUSECLR=1 in RUN; RSTCAUSECLR is ignored in other states.
REQ-025 SHALL, when RSTCAUSECLR and a RUN-state req occur in the same cycle, set RSTCAUSE to the new cause bits only.
REQ-026 SHALL have cnt saturate and not wrap; cnt is CNT_W bits, unsigned.
REQ-027 SHALL treat LOCKUP with LOCKUPRESET=0 as having no effect.

Reset
REQ-028 SHALL reset synchronously on PORESET=1 as follows: state=POR_HOLD, cnt=0, synchroniser flops=1 (inactive), RSTCAUSE=4'b0001.
REQ-029 SHALL, during reset, drive HRESETn=0 and DBGRESETn=0.
REQ-030 SHALL, on PORESET mid-SYS_HOLD or mid-count, take POR_HOLD on the next edge and restart the count.

Structure
REQ-031 SHALL place the state encoding, the RSTCAUSE bit indices and the HOLD default in a shared package cm0ik_rst_pkg.
REQ-032 SHALL implement the two-flop synchroniser as sub-module cm0ik_rst_sync (1 bit, reset value parameterised).

Verification
REQ-033 SHALL cover: PORESET=1 for 2 cycles then 0 -> HRESETn=DBGRESETn=0 throughout, both 1 on 3rd edge after fall, RSTCAUSE=4'b0001.
REQ-034 SHALL cover: in RUN, SYSRESETREQ=1 for 1 cycle -> HRESETn=0 next edge, DBGRESETn stays 1, HRESETn=1 on 3rd edge after request drop, RSTCAUSE=4'b0011.
REQ-035 SHALL cover: LOCKUP=1, LOCKUPRESET=0 -> HRESETn stays 1; then LOCKUPRESET=1 -> SYS_HOLD, RSTCAUSE[2]=1.
REQ-036 SHALL cover: EXTRESETn low for 2 cycles -> HRESETn=0 on 3rd edge after first low sample, RSTCAUSE[3]=1, release 3 edges after ext_req drops.
REQ-037 SHALL cover: RSTCAUSE=4'b0111 with RSTCAUSECLR and SYSRESETREQ in the same RUN cycle -> RSTCAUSE=4'b0010.
REQ-038 SHALL cover: PORESET=1 mid SYS_HOLD -> DBGRESETn=0 next edge, RSTCAUSE=4'b0001, full 3-cycle hold after PORESET falls.
